axi4_lite_mst_xactor: RTL and testbench



---
 rtl/axi4_lite_if.sv | 53 +++++
 rtl/axi4_lite_mst_xactor.sv | 277 +++++++++++++++++++++++++++
 tb/tb_axi4_lite_mst_xactor.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_if.sv
// ---------------------------------------------------------------------------
// axi4_lite_if
// AXI4-Lite bus bundle shared by one initiator and one target.
//   Parameters : ADDR_BIT_WIDTH (address width), DATA_BIT_WIDTH (32 or 64)
//   Modports   : mst_port - initiator view (drives AW/W/AR payload+valid,
//                           B/R ready)
//                slv_port - target view (drives AW/W/AR ready, B/R payload
//                           + valid)
// The bus is clocked by the clock of whichever block drives it; no clock is
// carried inside the bundle.
// ---------------------------------------------------------------------------
interface axi4_lite_if #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32
);
    localparam int STRB_BIT_WIDTH = DATA_BIT_WIDTH / 8;

    logic [ADDR_BIT_WIDTH-1:0] awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_BIT_WIDTH-1:0] wdata;
    logic [STRB_BIT_WIDTH-1:0] wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [ADDR_BIT_WIDTH-1:0] araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_BIT_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport mst_port (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slv_port (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );
endinterface

// File: rtl/axi4_lite_mst_xactor.sv
// ---------------------------------------------------------------------------
// axi4_lite_mst_xactor
// Turns single-beat register commands into AXI4-Lite read/write transactions,
// one outstanding at a time, and returns the result on a valid/ready port.
//   i_clk, i_sync_rst         : clock, synchronous active-high reset
//   if_m_axi (mst_port)       : AXI4-Lite initiator side
//   i_cmd_* / o_cmd_ready     : command (wr, byte addr, wdata, wstrb)
//   o_rsp_* / i_rsp_ready     : response (wr echo, rdata, rresp/bresp)
//   o_timeout                 : sticky watchdog flag (optional build only)
// Optional feature: define AXI4_LITE_MST_XACTOR_TIMEOUT_EN to add a watchdog
// that answers with resp=2'b10 after TIMEOUT_CYCLES cycles in a bus state.
// All outputs are registered.
// ---------------------------------------------------------------------------
module axi4_lite_mst_xactor #(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_sync_rst,
    axi4_lite_if.mst_port               if_m_axi,
    input  logic                        i_cmd_valid,
    output logic                        o_cmd_ready,
    input  logic                        i_cmd_wr,
    input  logic [ADDR_BIT_WIDTH-1:0]   i_cmd_addr,
    input  logic [DATA_BIT_WIDTH-1:0]   i_cmd_wdata,
    input  logic [DATA_BIT_WIDTH/8-1:0] i_cmd_wstrb,
    output logic                        o_rsp_valid,
    input  logic                        i_rsp_ready,
    output logic                        o_rsp_wr,
    output logic [DATA_BIT_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]                  o_rsp_resp
`ifdef AXI4_LITE_MST_XACTOR_TIMEOUT_EN
    ,
    output logic                        o_timeout
`endif
);
    localparam int STRB_W = DATA_BIT_WIDTH / 8;

    if ((DATA_BIT_WIDTH != 32'sd32) && (DATA_BIT_WIDTH != 32'sd64)) begin : g_bad_data_width
        $error("axi4_lite_mst_xactor: DATA_BIT_WIDTH must be 32 or 64");
    end
    if (TIMEOUT_CYCLES < 32'sd2) begin : g_bad_timeout
        $error("axi4_lite_mst_xactor: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                    state_r, state_nxt_s;
    logic                      cmd_ready_r, wr_r;
    logic                      awvalid_r, wvalid_r, arvalid_r, bready_r, rready_r;
    logic                      aw_done_r, w_done_r;
    logic [ADDR_BIT_WIDTH-1:0] awaddr_r, araddr_r;
    logic [DATA_BIT_WIDTH-1:0] wdata_r;
    logic [STRB_W-1:0]         wstrb_r;
    logic                      rsp_valid_r, rsp_wr_r;
    logic [DATA_BIT_WIDTH-1:0] rsp_rdata_r, rsp_rdata_nxt_s;
    logic [1:0]                rsp_resp_r, rsp_resp_nxt_s;
    logic                      rsp_load_s, rsp_wr_nxt_s;
    logic                      accept_s, aw_hs_s, w_hs_s, ar_hs_s, b_hs_s, r_hs_s;
    logic                      aw_fin_s, w_fin_s;
    logic                      tmo_hit_s, tmo_sticky_s;

    assign accept_s = i_cmd_valid & cmd_ready_r;
    assign aw_hs_s  = awvalid_r & if_m_axi.awready;
    assign w_hs_s   = wvalid_r & if_m_axi.wready;
    assign ar_hs_s  = arvalid_r & if_m_axi.arready;
    assign b_hs_s   = bready_r & if_m_axi.bvalid;
    assign r_hs_s   = rready_r & if_m_axi.rvalid;
    // A channel counts as finished if it completed earlier or completes now.
    assign aw_fin_s = aw_done_r | aw_hs_s;
    assign w_fin_s  = w_done_r | w_hs_s;

`ifdef AXI4_LITE_MST_XACTOR_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic             timeout_r;
    logic             bus_wait_s;

    assign bus_wait_s   = (state_r == WR_AW_W) || (state_r == WR_B) ||
                          (state_r == RD_AR) || (state_r == RD_R);
    // Counter holds the number of cycles already spent in the state, so the
    // hit fires in the TIMEOUT_CYCLES-th cycle of waiting.
    assign tmo_hit_s    = bus_wait_s && (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));
    assign tmo_sticky_s = timeout_r | tmo_hit_s;
    assign o_timeout    = timeout_r;

    // Watchdog counter (cleared on each state entry) and sticky timeout flag.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            if (state_nxt_s != state_r) begin
                tmo_cnt_r <= {TMO_W{1'b0}};
            end else if (bus_wait_s && !tmo_hit_s) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1'b1);
            end
            timeout_r <= tmo_sticky_s;
        end
    end
`else
    assign tmo_hit_s    = 1'b0;
    assign tmo_sticky_s = 1'b0;
`endif

    // Next-state logic and the response payload captured on entry to RSP.
    always_comb begin
        state_nxt_s     = state_r;
        rsp_load_s      = 1'b0;
        rsp_wr_nxt_s    = wr_r;
        rsp_resp_nxt_s  = 2'b00;
        rsp_rdata_nxt_s = {DATA_BIT_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = i_cmd_wr ? WR_AW_W : RD_AR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WR_AW_W: begin
                if (aw_fin_s && w_fin_s) begin
                    state_nxt_s = WR_B;
                end else if (tmo_hit_s) begin
                    state_nxt_s    = RSP;
                    rsp_load_s     = 1'b1;
                    rsp_resp_nxt_s = 2'b10;
                end else begin
                    state_nxt_s = WR_AW_W;
                end
            end
            WR_B: begin
                if (b_hs_s) begin
                    state_nxt_s    = RSP;
                    rsp_load_s     = 1'b1;
                    rsp_resp_nxt_s = if_m_axi.bresp;
                end else if (tmo_hit_s) begin
                    state_nxt_s    = RSP;
                    rsp_load_s     = 1'b1;
                    rsp_resp_nxt_s = 2'b10;
                end else begin
                    state_nxt_s = WR_B;
                end
            end
            RD_AR: begin
                if (ar_hs_s) begin
                    state_nxt_s = RD_R;
                end else if (tmo_hit_s) begin
                    state_nxt_s    = RSP;
                    rsp_load_s     = 1'b1;
                    rsp_resp_nxt_s = 2'b10;
                end else begin
                    state_nxt_s = RD_AR;
                end
            end
            RD_R: begin
                if (r_hs_s) begin
                    state_nxt_s     = RSP;
                    rsp_load_s      = 1'b1;
                    rsp_resp_nxt_s  = if_m_axi.rresp;
                    rsp_rdata_nxt_s = if_m_axi.rdata;
                end else if (tmo_hit_s) begin
                    state_nxt_s    = RSP;
                    rsp_load_s     = 1'b1;
                    rsp_resp_nxt_s = 2'b10;
                end else begin
                    state_nxt_s = RD_R;
                end
            end
            RSP: begin
                if (i_rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RSP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Registered bus/command/response outputs and the latched command.
    always_ff @(posedge i_clk) begin
        if (i_sync_rst) begin
            cmd_ready_r <= 1'b1;
            wr_r        <= 1'b0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            bready_r    <= 1'b0;
            rready_r    <= 1'b0;
            aw_done_r   <= 1'b0;
            w_done_r    <= 1'b0;
            awaddr_r    <= {ADDR_BIT_WIDTH{1'b0}};
            araddr_r    <= {ADDR_BIT_WIDTH{1'b0}};
            wdata_r     <= {DATA_BIT_WIDTH{1'b0}};
            wstrb_r     <= {STRB_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_wr_r    <= 1'b0;
            rsp_rdata_r <= {DATA_BIT_WIDTH{1'b0}};
            rsp_resp_r  <= 2'b00;
        end else begin
            // After a watchdog hit the block refuses new work until reset.
            cmd_ready_r <= (state_nxt_s == IDLE) && !tmo_sticky_s;
            if (accept_s) begin
                wr_r <= i_cmd_wr;
                if (i_cmd_wr) begin
                    awaddr_r <= i_cmd_addr;
                    wdata_r  <= i_cmd_wdata;
                    wstrb_r  <= i_cmd_wstrb;
                end else begin
                    araddr_r <= i_cmd_addr;
                end
            end
            // Valids rise on acceptance and fall only on their own handshake,
            // so a timed-out request stays asserted on the bus.
            if (accept_s && i_cmd_wr) begin
                awvalid_r <= 1'b1;
                wvalid_r  <= 1'b1;
            end else begin
                if (aw_hs_s) awvalid_r <= 1'b0;
                if (w_hs_s)  wvalid_r  <= 1'b0;
            end
            if (accept_s && !i_cmd_wr) begin
                arvalid_r <= 1'b1;
            end else if (ar_hs_s) begin
                arvalid_r <= 1'b0;
            end
            aw_done_r   <= (state_nxt_s == WR_AW_W) && aw_fin_s;
            w_done_r    <= (state_nxt_s == WR_AW_W) && w_fin_s;
            bready_r    <= (state_nxt_s == WR_B);
            rready_r    <= (state_nxt_s == RD_R);
            rsp_valid_r <= (state_nxt_s == RSP);
            if (rsp_load_s) begin
                rsp_wr_r    <= rsp_wr_nxt_s;
                rsp_resp_r  <= rsp_resp_nxt_s;
                rsp_rdata_r <= rsp_rdata_nxt_s;
            end
        end
    end

    assign if_m_axi.awaddr  = awaddr_r;
    assign if_m_axi.awprot  = 3'b000;
    assign if_m_axi.awvalid = awvalid_r;
    assign if_m_axi.wdata   = wdata_r;
    assign if_m_axi.wstrb   = wstrb_r;
    assign if_m_axi.wvalid  = wvalid_r;
    assign if_m_axi.bready  = bready_r;
    assign if_m_axi.araddr  = araddr_r;
    assign if_m_axi.arprot  = 3'b000;
    assign if_m_axi.arvalid = arvalid_r;
    assign if_m_axi.rready  = rready_r;

    assign o_cmd_ready = cmd_ready_r;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_wr    = rsp_wr_r;
    assign o_rsp_rdata = rsp_rdata_r;
    assign o_rsp_resp  = rsp_resp_r;
endmodule

// File: tb/tb_axi4_lite_mst_xactor.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_mst_xactor
// Directed bench: a table of command/slave-behaviour records with
// hand-computed expectations, a reactive AXI4-Lite target, plus hand-written
// sequences for mid-transaction reset and (optional build) the watchdog.
// ---------------------------------------------------------------------------
module tb_axi4_lite_mst_xactor;
    localparam int TMO = 8;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] sdata;
        logic [1:0]  sresp;
        int          aw_dly;
        int          w_dly;
        int          ar_dly;
        int          rsp_dly;
        int          exp_lat;
        int          exp_held;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_wr;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
`ifdef AXI4_LITE_MST_XACTOR_TIMEOUT_EN
    logic        timeout;
`endif

    int checks = 0;
    int failures = 0;

    axi4_lite_if #(.ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32)) axi();

    axi4_lite_mst_xactor #(
        .ADDR_BIT_WIDTH(32), .DATA_BIT_WIDTH(32), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_sync_rst(rst), .if_m_axi(axi),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr(cmd_wr),
        .i_cmd_addr(cmd_addr), .i_cmd_wdata(cmd_wdata), .i_cmd_wstrb(cmd_wstrb),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_wr(rsp_wr),
        .o_rsp_rdata(rsp_rdata), .o_rsp_resp(rsp_resp)
`ifdef AXI4_LITE_MST_XACTOR_TIMEOUT_EN
        , .o_timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = 32'h0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int aw_n = 0, w_n = 0, ar_n = 0, rsp_n = 0, first_c = -1, wait_n = 0;
        int aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, b_hs_n = 0, r_hs_n = 0;
        int viol = 0, unstable = 0;
        logic aw_d = 1'b0, w_d = 1'b0, ar_d = 1'b0, b_d = 1'b0, r_d = 1'b0, done = 1'b0;
        logic p_awv = 1'b0, p_wv = 1'b0, p_arv = 1'b0;
        logic p_awhs = 1'b0, p_whs = 1'b0, p_arhs = 1'b0;
        logic        cap_wr = 1'b0;
        logic [1:0]  cap_resp = 2'b00;
        logic [31:0] cap_rdata = 32'h0;
        logic [39:0] hs_cnt, hs_exp;

        while (!cmd_ready && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        chk({tag, "_cmd_ready_idle"}, cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_wr = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;

        for (int c = 1; c <= 64 && !done; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (c == 1) chk({tag, "_cmd_ready_drop"}, cmd_ready, 1'b0);
            if ((p_awv && !p_awhs && !axi.awvalid) || (p_wv && !p_whs && !axi.wvalid) ||
                (p_arv && !p_arhs && !axi.arvalid)) viol++;
            // reactive target
            axi.awready = axi.awvalid && (aw_n >= v.aw_dly);
            axi.wready  = axi.wvalid && (w_n >= v.w_dly);
            axi.arready = axi.arvalid && (ar_n >= v.ar_dly);
            axi.bvalid  = aw_d && w_d && !b_d;
            axi.bresp   = v.sresp;
            axi.rvalid  = ar_d && !r_d;
            axi.rresp   = v.sresp;
            axi.rdata   = v.sdata;
            if (axi.awvalid) aw_n++;
            if (axi.wvalid)  w_n++;
            if (axi.arvalid) ar_n++;
            rsp_ready = rsp_valid && (rsp_n >= v.rsp_dly);
            if (rsp_valid) begin
                if (rsp_n == 0) begin
                    first_c = c; cap_wr = rsp_wr; cap_resp = rsp_resp; cap_rdata = rsp_rdata;
                end else if ({rsp_wr, rsp_resp, rsp_rdata} !== {cap_wr, cap_resp, cap_rdata}) begin
                    unstable++;
                end
                rsp_n++;
            end
            // handshakes completing at the coming edge
            p_awhs = axi.awvalid && axi.awready;
            p_whs  = axi.wvalid && axi.wready;
            p_arhs = axi.arvalid && axi.arready;
            if (p_awhs) begin
                aw_hs_n++; aw_d = 1'b1;
                chk({tag, "_awaddr"}, axi.awaddr, v.addr);
            end
            if (p_whs) begin
                w_hs_n++; w_d = 1'b1;
                chk({tag, "_wdata"}, axi.wdata, v.wdata);
                chk({tag, "_wstrb"}, axi.wstrb, v.wstrb);
            end
            if (p_arhs) begin
                ar_hs_n++; ar_d = 1'b1;
                chk({tag, "_araddr"}, axi.araddr, v.addr);
            end
            if (axi.bvalid && axi.bready) begin b_hs_n++; b_d = 1'b1; end
            if (axi.rvalid && axi.rready) begin r_hs_n++; r_d = 1'b1; end
            if (rsp_valid && rsp_ready) done = 1'b1;
            p_awv = axi.awvalid; p_wv = axi.wvalid; p_arv = axi.arvalid;
        end

        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_latency"}, first_c, v.exp_lat);
        chk({tag, "_held"}, rsp_n, v.exp_held);
        chk({tag, "_resp"}, cap_resp, v.exp_resp);
        chk({tag, "_rdata"}, cap_rdata, v.exp_rdata);
        chk({tag, "_wr"}, cap_wr, v.wr);
        chk({tag, "_stable"}, unstable, 0);
        chk({tag, "_valid_hold"}, viol, 0);
        hs_cnt = {aw_hs_n[7:0], w_hs_n[7:0], b_hs_n[7:0], ar_hs_n[7:0], r_hs_n[7:0]};
        hs_exp = v.wr ? 40'h01_01_01_00_00 : 40'h00_00_00_01_01;
        chk({tag, "_hs_counts"}, hs_cnt, hs_exp);

        @(negedge clk);
        rsp_ready = 1'b0;
        slave_idle();
        chk({tag, "_cmd_ready_back"}, cmd_ready, 1'b1);
        chk({tag, "_rsp_valid_low"}, rsp_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t vecs[7];
        int   n;
        logic stuck;
        //         wr    addr          wdata         strb     sdata         sresp  aw w ar rsp lat held exp_resp exp_rdata
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF,    32'h1111_1111, 2'b00, 0, 0, 0, 0, 3, 1, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0,    32'h1234_5678, 2'b00, 0, 0, 0, 0, 3, 1, 2'b00, 32'h1234_5678};
        vecs[2] = '{1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 4'b0101, 32'h2222_2222, 2'b00, 0, 3, 0, 0, 6, 1, 2'b00, 32'h0};
        vecs[3] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0,    32'hCAFE_F00D, 2'b11, 0, 0, 0, 5, 3, 6, 2'b11, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 4'b1000, 32'h3333_3333, 2'b10, 2, 1, 0, 1, 5, 2, 2'b10, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0,    32'hFFFF_FFFF, 2'b01, 0, 0, 2, 0, 5, 1, 2'b01, 32'hFFFF_FFFF};
        vecs[6] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0,    32'h0BAD_C0DE, 2'b00, 0, 0, 0, 0, 3, 1, 2'b00, 32'h0BAD_C0DE};

        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 32'h0;
        cmd_wdata = 32'h0; cmd_wstrb = 4'h0; rsp_ready = 1'b0;
        slave_idle();
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_rsp", {rsp_valid, rsp_wr, rsp_resp, rsp_rdata}, 36'h0);
        chk("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
        chk("rst_payload", {axi.awaddr, axi.araddr, axi.wdata, axi.wstrb}, 100'h0);
        chk("rst_prot", {axi.awprot, axi.arprot}, 6'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // reset while waiting for the write response
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'h0000_0030;
        cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
        n = 0;
        do begin
            @(negedge clk);
            cmd_valid = 1'b0;
            axi.awready = axi.awvalid;
            axi.wready  = axi.wvalid;
            n++;
        end while (!axi.bready && n < 10);
        chk("mid_rst_reached_wr_b", axi.bready, 1'b1);
        axi.awready = 1'b0; axi.wready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        run_txn(vecs[6], "post_rst");

`ifdef AXI4_LITE_MST_XACTOR_TIMEOUT_EN
        // target never raises arready: watchdog answers after TMO cycles
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 32'h0000_0050;
        n = -1;
        for (int c = 1; c <= 30 && n < 0; c++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rsp_valid) n = c;
        end
        chk("tmo_latency", n, TMO + 1);
        chk("tmo_resp", rsp_resp, 2'b10);
        chk("tmo_rdata", rsp_rdata, 32'h0);
        chk("tmo_flag", timeout, 1'b1);
        chk("tmo_arvalid_held", axi.arvalid, 1'b1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("tmo_rsp_taken", rsp_valid, 1'b0);
        stuck = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (cmd_ready) stuck = 1'b1;
            @(negedge clk);
        end
        chk("tmo_cmd_ready_stays_low", stuck, 1'b0);
        chk("tmo_flag_sticky", timeout, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("tmo_flag_cleared", timeout, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
